uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL expose parameter CLK_PER_BIT, default 100, clk cycles per serial bit; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port data  input  8  byte to transmit, sampled on accept.
REQ-005 SHALL have port valid  input  1  data valid request from producer.
REQ-006 SHALL have port ready  output  1  holding buffer empty; byte accepted when valid && ready at rising edge.
REQ-007 SHALL have port serial_line  output  1  registered UART line, idle high.
REQ-008 SHALL have port busy  output  1  high while a frame is in progress or the holding buffer is full.

Function
REQ-009 SHALL transmit 8N1 frames: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-010 SHALL hold every bit on serial_line for exactly CLK_PER_BIT cycles; frame length exactly 10*CLK_PER_BIT cycles.
REQ-011 SHALL contain a one-byte holding buffer plus a separate shift register (double buffering).
REQ-012 SHALL load data into the holding buffer on accept; ready SHALL equal !buffer_full, registered.
REQ-013 SHALL ignore valid while ready is low; data and buffer remain unchanged.
REQ-014 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-015 IDLE: serial_line=1; on edge with buffer full -> copy buffer to shift register, clear buffer, enter START.
REQ-016 START: serial_line=0 for CLK_PER_BIT cycles -> DATA with bit index 0.
REQ-017 DATA: serial_line=shift[index]; after CLK_PER_BIT cycles, index increments; after index 7 -> STOP.
REQ-018 STOP: serial_line=1 for CLK_PER_BIT cycles; at expiry, buffer full -> START directly (copy/clear as REQ-015, zero idle cycles), else -> IDLE.
REQ-019 Latency: byte accepted at edge N with FSM IDLE -> serial_line low from edge N+1 through N+CLK_PER_BIT.
REQ-020 Buffer drain edge and ready rise coincide; a new byte is accepted no earlier than the following edge (no simultaneous accept and drain).
REQ-021 Bit-period counter SHALL be $clog2(CLK_PER_BIT) bits wide, count 0..CLK_PER_BIT-1, wrap to 0 on each bit boundary, no off-by-one across frames.
REQ-022 busy SHALL be high whenever state != IDLE or buffer full; low only when line idle and buffer empty.
REQ-023 data changes while a frame is in flight SHALL NOT affect the frame being sent.

Reset
REQ-024 rst_n low SHALL immediately (asynchronously) force serial_line=1, ready=1, busy=0, state IDLE, buffer empty, counters and bit index 0.
REQ-025 Reset mid-frame SHALL abort the frame and discard the buffered byte; no partial bits after rst_n deasserts.
REQ-026 First accept SHALL be possible on the first rising edge after rst_n deasserts.

Verification (CLK_PER_BIT=4 unless stated)
REQ-027 Accept 0xA5 from idle -> serial_line 0,1,0,1,0,0,1,0,1,1, each 4 cycles, starting edge after accept; busy low 40 cycles after start.
REQ-028 Accept 0x00 then 0xFF as soon as ready allows -> 80 contiguous frame cycles, no idle-high gap between stop of first and start of second; ready low while buffer full.
REQ-029 Hold valid high with data 0x3C while buffer full -> byte not re-accepted; exactly the expected number of frames transmitted.
REQ-030 Assert rst_n low 13 cycles into frame of 0x81 with 0x42 buffered -> serial_line=1 immediately, ready=1, busy=0; neither byte resumes after release.
REQ-031 Loopback into the team UART receiver, CLK_PER_BIT=100, all bytes 0x00..0xFF back-to-back -> receiver reports ready with data equal to each byte, zero mismatches.

Source files
------------

// File: rtl/uart_tx.sv
// uart_tx: 8N1 UART transmitter with a one-byte holding buffer in front of the shift register.
module uart_tx #(
    parameter int CLK_PER_BIT = 100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       serial_line,
    output logic       busy
);
    localparam int CW = $clog2(CLK_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLK_PER_BIT - 1);
    localparam logic [1:0] IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3;
    logic [1:0]    state;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic [7:0]    hold;
    logic          full;
    logic          tick;
    always_comb begin
        tick = cnt == LAST;
        busy = state != IDLE || full;
    end
    // Accept needs an empty buffer and a drain needs a full one, so they never share an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shift       <= '0;
            hold        <= '0;
            full        <= 1'b0;
            ready       <= 1'b1;
            serial_line <= 1'b1;
        end else begin
            if (valid && ready) begin
                hold  <= data;
                full  <= 1'b1;
                ready <= 1'b0;
            end
            if (state != IDLE) cnt <= tick ? '0 : cnt + 1'b1;
            case (state)
                IDLE: if (full) begin
                    shift       <= hold;
                    full        <= 1'b0;
                    ready       <= 1'b1;
                    state       <= START;
                    serial_line <= 1'b0;
                end
                START: if (tick) begin
                    state       <= DATA;
                    idx         <= '0;
                    serial_line <= shift[0];
                end
                DATA: if (tick) begin
                    if (idx == 3'd7) begin
                        state       <= STOP;
                        serial_line <= 1'b1;
                    end else begin
                        idx         <= idx + 3'd1;
                        serial_line <= shift[idx + 3'd1];
                    end
                end
                STOP: if (tick) begin
                    if (full) begin
                        shift       <= hold;
                        full        <= 1'b0;
                        ready       <= 1'b1;
                        state       <= START;
                        serial_line <= 1'b0;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and random stimulus checked cycle by cycle against a timeline model of frames.
module tb_uart_tx;
    localparam int CPB = 4;
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] data = 8'h00;
    logic       valid = 1'b0;
    logic       ready, serial_line, busy;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    logic       m_full = 1'b0;
    logic [7:0] m_buf = 8'h00;
    logic       m_act = 1'b0;
    int         m_start = 0;
    logic [9:0] m_frame = 10'h3ff;
    logic       last_acc = 1'b0;

    uart_tx #(.CLK_PER_BIT(CPB)) dut (
        .clk(clk), .rst_n(rst_n), .data(data), .valid(valid),
        .ready(ready), .serial_line(serial_line), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc %0d observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    // Model: a byte waits in the buffer until the line is free, then occupies 10*CPB cycles.
    task automatic step(input logic v, input logic [7:0] d);
        logic       acc;
        logic [3:0] k;
        valid = v;
        data  = d;
        @(posedge clk);
        cyc++;
        acc = v && !m_full;
        last_acc = acc;
        if (m_act && cyc == m_start + 10 * CPB) m_act = 1'b0;
        if (m_full && !m_act) begin
            m_act   = 1'b1;
            m_start = cyc;
            m_frame = {1'b1, m_buf, 1'b0};
            m_full  = 1'b0;
        end
        if (acc) begin
            m_full = 1'b1;
            m_buf  = d;
        end
        @(negedge clk);
        k = 4'((cyc - m_start) / CPB);
        chk("line", serial_line, m_act ? m_frame[k] : 1'b1);
        chk("ready", ready, !m_full);
        chk("busy", busy, m_act || m_full);
    endtask

    task automatic send(input logic [7:0] b);
        int n = 0;
        do begin
            step(1'b1, b);
            n++;
        end while (!last_acc && n < 200);
        chk("send_accept", last_acc, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 8'($urandom));
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_act || m_full) && n < 1000) begin
            step(1'b0, 8'($urandom));
            n++;
        end
        chk("wait_idle", m_act || m_full, 1'b0);
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_line", serial_line, 1'b1);
        chk("rst_ready", ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        m_full = 1'b0;
        m_act  = 1'b0;
        @(negedge clk);
        chk("rst_hold_line", serial_line, 1'b1);
        chk("rst_hold_busy", busy, 1'b0);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        #1 rst_n = 1'b0;
        #2;
        chk("init_line", serial_line, 1'b1);
        chk("init_ready", ready, 1'b1);
        chk("init_busy", busy, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        // Single frame from idle, accepted on the first edge after reset.
        send(8'hA5);
        idle(45);
        // Two frames back to back with no idle gap.
        send(8'h00);
        send(8'hFF);
        wait_idle();
        idle(3);
        // valid held high while the buffer is full must not re-accept.
        send(8'h11);
        send(8'h3C);
        repeat (20) step(1'b1, 8'h3C);
        wait_idle();
        idle(3);
        // Random traffic with data churning mid-frame.
        repeat (800) step($urandom_range(0, 3) == 0, 8'($urandom));
        wait_idle();
        idle(2);
        // Reset 13 cycles into a frame with a second byte buffered.
        send(8'h81);
        send(8'h42);
        n = 0;
        while (cyc - m_start < 13 && n < 100) begin
            step(1'b0, 8'h00);
            n++;
        end
        chk("reached_cycle13", cyc - m_start == 13, 1'b1);
        async_reset();
        idle(60);
        send(8'h5A);
        wait_idle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
